mul_err_sweeper: RTL
====================

MUL_ERR_SWEEPER -- requirements
Module: mul_err_sweeper

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 6, SHALL set the operand width of the multiplier under test.
REQ-003 Parameter LAT, default 0, SHALL set the multiplier latency in clock cycles, from operands to product.
REQ-004 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 start  input  1  SHALL be the sweep request; sampled only in IDLE and DONE.
REQ-007 mul_in1  output  WIDTH  SHALL be operand 1 driven to the multiplier's in1.
REQ-008 mul_in2  output  WIDTH  SHALL be operand 2 driven to the multiplier's in2.
REQ-009 mul_out  input  2*WIDTH  SHALL be the product returned by the multiplier's out.
REQ-010 busy  output  1  SHALL be high in SWEEP and DRAIN.
REQ-011 done  output  1  SHALL be high in DONE.
REQ-012 err_count  output  2*WIDTH+1  SHALL count samples where mul_out differs from the exact product.
REQ-013 max_err  output  2*WIDTH  SHALL hold the largest absolute error seen.
REQ-014 sum_err  output  4*WIDTH  SHALL hold the accumulated absolute error distance.

Function
REQ-015 The FSM SHALL have the states IDLE, SWEEP, DRAIN and DONE.
REQ-016 Transitions: IDLE or DONE with start=1 -> SWEEP, clearing all accumulators on that edge; SWEEP -> DRAIN after the last operand pair (or -> DONE if LAT=0); DRAIN -> DONE after LAT cycles; DONE holds until start.
REQ-017 A 2*WIDTH-bit counter SHALL step by 1 once per SWEEP cycle, starting at 0; mul_in1 = cnt[WIDTH-1:0], mul_in2 = cnt[2*WIDTH-1:WIDTH]; all 2^(2*WIDTH) pairs are presented exactly once.
REQ-018 mul_in1/mul_in2 SHALL be registered outputs and SHALL hold 0 outside SWEEP.
REQ-019 A LAT-deep shift register SHALL carry the operands and a valid bit alongside the product, so that the operands tagging mul_out are the pair presented LAT cycles earlier.
REQ-020 When the tail entry is valid, the block SHALL compute exact = op1*op2 (unsigned, 2*WIDTH bits) and err = |mul_out - exact|.
REQ-021 On a valid sample with err != 0: err_count +1, sum_err += err, and max_err = max(max_err, err).
REQ-022 Timing: start seen at edge k -> SWEEP over cycles k+1 .. k+2^(2*WIDTH) -> done=1 from cycle k+2^(2*WIDTH)+LAT+1.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 The counter SHALL NOT wrap inside a sweep; all-ones is the last SWEEP cycle.
REQ-025 Accumulators SHALL NOT saturate; the widths above are sufficient and are the required widths.
REQ-026 The results SHALL stay stable in DONE until the next start or rst.

Reset
REQ-027 rst SHALL, on any edge and in any state (including mid-sweep), force IDLE, zero the counter, the pipeline and the valid bits, and set every output to 0.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro MUL_SWEEP_SIGNED_ERR_EN defined: an extra output bias_sum (output, 4*WIDTH+1 bits, two's complement) SHALL accumulate (mul_out - exact) on every valid sample; it clears on start and rst.
REQ-030 Macro undefined: the bias_sum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=6, LAT=0, exact combinational model, start pulse at k -> done rises at k+4097; err_count=0, max_err=0, sum_err=0.
REQ-032 WIDTH=6, LAT=0, model forcing product bit0=0 -> err_count=1024, sum_err=1024, max_err=1; with MUL_SWEEP_SIGNED_ERR_EN, bias_sum=-1024.
REQ-033 WIDTH=6, LAT=2, exact model with a 2-stage product register -> zero errors; done rises at k+4099.
REQ-034 Model forcing bit0=1 -> err_count=3072, sum_err=3072, max_err=1.
REQ-035 rst at the 100th SWEEP cycle -> next cycle IDLE, all outputs 0; a new start then yields the same results as REQ-031.
REQ-036 Repeated start pulses while busy -> no restart; results and done timing are identical to a single start.

Source files
------------

// File: rtl/mul_err_sweeper_if.sv
// Operand/product and result bus between the error sweeper (master) and the multiplier plus result sink (slave).
// bias_sum exists only when MUL_SWEEP_SIGNED_ERR_EN is defined.
interface mul_err_sweeper_if #(
  parameter int WIDTH = 6
);
  logic                   start;
  logic [WIDTH-1:0]       mul_in1;
  logic [WIDTH-1:0]       mul_in2;
  logic [2*WIDTH-1:0]     mul_out;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH:0]       err_count;
  logic [2*WIDTH-1:0]     max_err;
  logic [4*WIDTH-1:0]     sum_err;
`ifdef MUL_SWEEP_SIGNED_ERR_EN
  logic signed [4*WIDTH:0] bias_sum;

  modport master (
    input  start, mul_out,
    output mul_in1, mul_in2, busy, done, err_count, max_err, sum_err, bias_sum
  );
  modport slave (
    output start, mul_out,
    input  mul_in1, mul_in2, busy, done, err_count, max_err, sum_err, bias_sum
  );
`else
  modport master (
    input  start, mul_out,
    output mul_in1, mul_in2, busy, done, err_count, max_err, sum_err
  );
  modport slave (
    output start, mul_out,
    input  mul_in1, mul_in2, busy, done, err_count, max_err, sum_err
  );
`endif
endinterface

// File: rtl/mul_err_sweeper.sv
// Exhaustive error sweeper: presents every operand pair to a LAT-cycle multiplier and accumulates error stats.
// Optional MUL_SWEEP_SIGNED_ERR_EN adds a signed bias accumulator (bias_sum).
module mul_err_sweeper #(
  parameter int WIDTH = 6,
  parameter int LAT   = 0
) (
  input logic             clk,
  input logic             rst,
  mul_err_sweeper_if.master bus
);
  localparam int CW = 2 * WIDTH;
  localparam int DW = $clog2(LAT + 1) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((LAT == 0) ? 0 : LAT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [CW:0]        err_count_q, err_count_d;
  logic [CW-1:0]      max_err_q, max_err_d;
  logic [4*WIDTH-1:0] sum_err_q, sum_err_d;

  logic               sweep_vld;
  logic               tail_vld;
  logic [WIDTH-1:0]   tail_op1, tail_op2;
  logic [CW-1:0]      exact;
  logic [CW-1:0]      err;
  logic [CW:0]        sdiff;

  assign sweep_vld = (state_q == SWEEP);

  // Operands travel with a valid bit so each product is matched to the pair that produced it.
  generate
    if (LAT == 0) begin : g_nopipe
      assign tail_vld = sweep_vld;
      assign tail_op1 = cnt_q[WIDTH-1:0];
      assign tail_op2 = cnt_q[CW-1:WIDTH];
    end else begin : g_pipe
      logic [LAT-1:0]   pvld_q;
      logic [WIDTH-1:0] pop1_q [LAT];
      logic [WIDTH-1:0] pop2_q [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          pvld_q <= '0;
          for (int i = 0; i < LAT; i++) begin
            pop1_q[i] <= '0;
            pop2_q[i] <= '0;
          end
        end else begin
          pvld_q[0] <= sweep_vld;
          pop1_q[0] <= cnt_q[WIDTH-1:0];
          pop2_q[0] <= cnt_q[CW-1:WIDTH];
          for (int i = 1; i < LAT; i++) begin
            pvld_q[i] <= pvld_q[i-1];
            pop1_q[i] <= pop1_q[i-1];
            pop2_q[i] <= pop2_q[i-1];
          end
        end
      end

      assign tail_vld = pvld_q[LAT-1];
      assign tail_op1 = pop1_q[LAT-1];
      assign tail_op2 = pop2_q[LAT-1];
    end
  endgenerate

  assign exact = CW'(tail_op1) * CW'(tail_op2);
  assign err   = (bus.mul_out >= exact) ? (bus.mul_out - exact) : (exact - bus.mul_out);
  assign sdiff = {1'b0, bus.mul_out} - {1'b0, exact};

`ifdef MUL_SWEEP_SIGNED_ERR_EN
  logic [4*WIDTH:0] bias_q, bias_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    err_count_d = err_count_q;
    max_err_d   = max_err_q;
    sum_err_d   = sum_err_q;
`ifdef MUL_SWEEP_SIGNED_ERR_EN
    bias_d      = bias_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = SWEEP;
          cnt_d       = '0;
          drain_d     = '0;
          err_count_d = '0;
          max_err_d   = '0;
          sum_err_d   = '0;
`ifdef MUL_SWEEP_SIGNED_ERR_EN
          bias_d      = '0;
`endif
        end
      end
      SWEEP: begin
        // Counter returns to zero on exit so the operand outputs read 0 outside SWEEP.
        if (cnt_q == '1) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = (LAT == 0) ? DONE : DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Samples only arrive in SWEEP/DRAIN, never on the clearing start edge.
    if (tail_vld && (err != '0)) begin
      err_count_d = err_count_q + 1'b1;
      sum_err_d   = sum_err_q + (4*WIDTH)'(err);
      if (err > max_err_q) begin
        max_err_d = err;
      end
    end
`ifdef MUL_SWEEP_SIGNED_ERR_EN
    if (tail_vld) begin
      bias_d = bias_q + {{(4*WIDTH-CW){sdiff[CW]}}, sdiff};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      err_count_q <= '0;
      max_err_q   <= '0;
      sum_err_q   <= '0;
`ifdef MUL_SWEEP_SIGNED_ERR_EN
      bias_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      err_count_q <= err_count_d;
      max_err_q   <= max_err_d;
      sum_err_q   <= sum_err_d;
`ifdef MUL_SWEEP_SIGNED_ERR_EN
      bias_q      <= bias_d;
`endif
    end
  end

  assign bus.mul_in1   = cnt_q[WIDTH-1:0];
  assign bus.mul_in2   = cnt_q[CW-1:WIDTH];
  assign bus.busy      = (state_q == SWEEP) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.err_count = err_count_q;
  assign bus.max_err   = max_err_q;
  assign bus.sum_err   = sum_err_q;
`ifdef MUL_SWEEP_SIGNED_ERR_EN
  assign bus.bias_sum  = $signed(bias_q);
`else
  // sdiff only feeds the bias accumulator.
  logic unused_sdiff;
  assign unused_sdiff = ^sdiff;
`endif
endmodule
